// File: rtl/tone_seq_pkg.sv
// Shared types and entry layout for the tone pattern sequencer.
package tone_seq_pkg;
    typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

    localparam int NOTE_W   = 4;
    localparam int ENTRY_W  = 5;
    localparam int REST_BIT = 4;

    localparam logic [ENTRY_W-1:0] REST_ENTRY = 5'b1_0000;
endpackage

// File: rtl/tone_seq_if.sv
// Control, pattern-write and playback signals of the tone sequencer.
interface tone_seq_if #(
    parameter int STEPS   = 16,
    parameter int TEMPO_W = 24
);
    localparam int AW = $clog2(STEPS);

    logic                             wr_en;
    logic [AW-1:0]                    wr_addr;
    logic [tone_seq_pkg::ENTRY_W-1:0] wr_data;
    logic [AW-1:0]                    len;
    logic [TEMPO_W-1:0]               tempo;
    logic                             loop;
    logic                             start;
    logic                             stop;
    logic [tone_seq_pkg::NOTE_W-1:0]  note;
    logic                             gate;
    logic [AW-1:0]                    step;
    logic                             busy;
    logic                             done;

    modport master (
        output wr_en, wr_addr, wr_data, len, tempo, loop, start, stop,
        input  note, gate, step, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, len, tempo, loop, start, stop,
        output note, gate, step, busy, done
    );
endinterface

// File: rtl/tone_seq_ram.sv
// Pattern store: STEPS x {rest, note}, one write port, one registered read port.
// Latency: read data valid the cycle after rd_en; a same-edge write returns the old entry.
// Backpressure: none, writes are accepted every cycle.
module tone_seq_ram
    import tone_seq_pkg::*;
#(
    parameter int STEPS = 16,
    parameter int AW    = $clog2(STEPS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               rd_en,
    input  logic [AW-1:0]      rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);
    logic [ENTRY_W-1:0] mem [STEPS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STEPS; i++) begin
                mem[i] <= REST_ENTRY;
            end
            rd_data <= REST_ENTRY;
        end else begin
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end
endmodule

// File: rtl/tone_sequencer.sv
// Steps a programmable note pattern at a programmable tempo, with a gate-low gap after each note.
// Latency: start sampled at edge 0 shows first note/gate/busy after edge 1; steps are gapless.
// Backpressure: none; start is ignored while busy, stop aborts immediately and wins over start.
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int STEPS      = 16,
    parameter int TEMPO_W    = 24,
    parameter int GAP_CYCLES = 1024
) (
    input logic       clk,
    input logic       reset,
    tone_seq_if.slave bus
);
    localparam int AW       = $clog2(STEPS);
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    state_t             state_q, state_d;
    logic [TEMPO_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]      step_q, step_d;
    logic               fin_q, fin_d;
    logic               advance;
    logic               rd_en;
    logic [AW-1:0]      rd_addr;
    logic [ENTRY_W-1:0] rd_data;

    logic [NOTE_W-1:0]  note_q;
    logic               gate_q, busy_q, done_q;
    logic [AW-1:0]      step_out_q;

    tone_seq_ram #(.STEPS(STEPS), .AW(AW)) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // The FSM runs one cycle ahead of the outputs so the entry read has time to land.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        fin_d   = 1'b0;
        advance = 1'b0;
        rd_en   = 1'b0;
        rd_addr = step_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !busy_q) begin
                    state_d = NOTE;
                    cnt_d   = bus.tempo;
                    step_d  = '0;
                    rd_en   = 1'b1;
                    rd_addr = '0;
                end
            end
            NOTE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (GAP_CYCLES > 0) begin
                    state_d = GAP;
                    cnt_d   = TEMPO_W'(GAP_LOAD);
                end else begin
                    advance = 1'b1;
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (step_q >= bus.len && !bus.loop) begin
                state_d = IDLE;
                fin_d   = 1'b1;
            end else begin
                step_d  = (step_q >= bus.len) ? '0 : step_q + 1'b1;
                state_d = NOTE;
                cnt_d   = bus.tempo;
                rd_en   = 1'b1;
                rd_addr = step_d;
            end
        end

        if (bus.stop) begin
            state_d = IDLE;
            fin_d   = 1'b0;
            rd_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            step_q  <= '0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            fin_q   <= fin_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            note_q     <= '0;
            gate_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            step_out_q <= '0;
        end else if (bus.stop) begin
            note_q <= '0;
            gate_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q     <= (state_q != IDLE);
            done_q     <= fin_q;
            step_out_q <= step_q;
            if (state_q != IDLE) begin
                note_q <= rd_data[NOTE_W-1:0];
                gate_q <= (state_q == NOTE) && !rd_data[REST_BIT];
            end else begin
                note_q <= '0;
                gate_q <= 1'b0;
            end
        end
    end

    assign bus.note = note_q;
    assign bus.gate = gate_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.step = step_out_q;
endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench: dut0 has GAP_CYCLES=2 (16 steps), dut1 has GAP_CYCLES=0 (4 steps).
module tb_tone_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;

    logic [3:0] nt [4] = '{4'd3, 4'd5, 4'd7, 4'd9};
    logic       rs [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    tone_seq_if #(.STEPS(16), .TEMPO_W(24)) bus0 ();
    tone_seq_if #(.STEPS(4),  .TEMPO_W(8))  bus1 ();

    tone_sequencer #(.STEPS(16), .TEMPO_W(24), .GAP_CYCLES(2)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    tone_sequencer #(.STEPS(4), .TEMPO_W(8), .GAP_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] pk0(input logic [3:0] n, input logic g, input logic b,
                                        input logic d, input logic [3:0] s);
        return {n, g, b, d, s};
    endfunction

    function automatic logic [10:0] obs0();
        return {bus0.note, bus0.gate, bus0.busy, bus0.done, bus0.step};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start0();
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        cyc = 0;
    endtask

    task automatic stop0();
        bus0.stop = 1'b1;
        tick();
        bus0.stop = 1'b0;
        tick();
    endtask

    task automatic write0(input logic [3:0] a, input logic [4:0] d);
        bus0.wr_en   = 1'b1;
        bus0.wr_addr = a;
        bus0.wr_data = d;
        tick();
        bus0.wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        total++;
        if (obs0() !== 11'd0) $display("FAIL reset_dut0 got=%h exp=000", obs0());
        else passed++;
        total++;
        if ({bus1.note, bus1.gate, bus1.busy, bus1.done, bus1.step} !== 9'd0)
            $display("FAIL reset_dut1 got=%h exp=000", {bus1.note, bus1.gate, bus1.busy, bus1.done, bus1.step});
        else passed++;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_pass();
        logic [10:0] e;
        int k, ph;
        bus0.tempo = 24'd9; bus0.len = 4'd3; bus0.loop = 1'b0;
        write0(4'd0, 5'h03);
        write0(4'd1, 5'h05);
        write0(4'd2, 5'h17);
        write0(4'd3, 5'h09);
        start0();
        total++;
        if (bus0.busy !== 1'b0) $display("FAIL single_c0_busy got=%b exp=0", bus0.busy);
        else passed++;
        for (int c = 1; c <= 50; c++) begin
            tick();
            k = (c - 1) / 12; ph = (c - 1) % 12;
            if (c <= 48) e = pk0(nt[k], (ph < 10) && !rs[k], 1'b1, 1'b0, 4'(k));
            else if (c == 49) e = pk0(4'd0, 1'b0, 1'b0, 1'b1, 4'd3);
            else e = pk0(4'd0, 1'b0, 1'b0, 1'b0, 4'd3);
            total++;
            if (obs0() !== e) $display("FAIL single_pass c=%0d got=%h exp=%h", c, obs0(), e);
            else passed++;
        end
    endtask

    task automatic test_loop_live_write();
        logic [10:0] e;
        logic [3:0]  n;
        int idx, k, ph;
        bus0.loop = 1'b1;
        start0();
        for (int c = 1; c <= 118; c++) begin
            tick();
            if (c == 64) bus0.wr_en = 1'b0;
            idx = (c - 1) % 48; k = idx / 12; ph = idx % 12;
            n = (k == 1 && c >= 97) ? 4'd12 : nt[k];
            e = pk0(n, (ph < 10) && !rs[k], 1'b1, 1'b0, 4'(k));
            total++;
            if (obs0() !== e) $display("FAIL loop_live c=%0d got=%h exp=%h", c, obs0(), e);
            else passed++;
            if (c == 63) begin
                bus0.wr_en = 1'b1; bus0.wr_addr = 4'd1; bus0.wr_data = 5'h0C;
            end
        end
        bus0.stop = 1'b1;
        tick();
        bus0.stop = 1'b0;
        total++;
        if ({bus0.note, bus0.gate, bus0.busy, bus0.done} !== 7'd0)
            $display("FAIL loop_stop got=%h exp=00", {bus0.note, bus0.gate, bus0.busy, bus0.done});
        else passed++;
        tick();
        write0(4'd1, 5'h05);
        bus0.loop = 1'b0;
    endtask

    task automatic test_stop();
        logic seen;
        start0();
        repeat (5) tick();
        total++;
        if ({bus0.gate, bus0.busy} !== 2'b11) $display("FAIL stop_pre got=%b exp=11", {bus0.gate, bus0.busy});
        else passed++;
        bus0.stop = 1'b1;
        tick();
        bus0.stop = 1'b0;
        total++;
        if ({bus0.note, bus0.gate, bus0.busy, bus0.done} !== 7'd0)
            $display("FAIL stop_c6 got=%h exp=00", {bus0.note, bus0.gate, bus0.busy, bus0.done});
        else passed++;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (bus0.done || bus0.busy) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) $display("FAIL stop_after got=%b exp=0", seen);
        else passed++;
    endtask

    task automatic test_start_stop_idle();
        bus0.start = 1'b1; bus0.stop = 1'b1;
        tick();
        bus0.start = 1'b0; bus0.stop = 1'b0;
        tick();
        tick();
        total++;
        if ({bus0.busy, bus0.gate} !== 2'b00) $display("FAIL start_stop_idle got=%b exp=00", {bus0.busy, bus0.gate});
        else passed++;
    endtask

    task automatic test_start_while_busy();
        start0();
        repeat (3) tick();
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        repeat (7) tick();
        total++;
        if (obs0() !== pk0(4'd3, 1'b0, 1'b1, 1'b0, 4'd0))
            $display("FAIL busy_start_c11 got=%h exp=%h", obs0(), pk0(4'd3, 1'b0, 1'b1, 1'b0, 4'd0));
        else passed++;
        repeat (2) tick();
        total++;
        if (obs0() !== pk0(4'd5, 1'b1, 1'b1, 1'b0, 4'd1))
            $display("FAIL busy_start_c13 got=%h exp=%h", obs0(), pk0(4'd5, 1'b1, 1'b1, 1'b0, 4'd1));
        else passed++;
        stop0();
    endtask

    task automatic test_len_zero();
        bus0.len = 4'd0; bus0.loop = 1'b1;
        start0();
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (c == 13 || c == 25) begin
                total++;
                if (obs0() !== pk0(4'd3, 1'b1, 1'b1, 1'b0, 4'd0))
                    $display("FAIL len0 c=%0d got=%h exp=%h", c, obs0(), pk0(4'd3, 1'b1, 1'b1, 1'b0, 4'd0));
                else passed++;
            end else if (c == 23) begin
                total++;
                if (obs0() !== pk0(4'd3, 1'b0, 1'b1, 1'b0, 4'd0))
                    $display("FAIL len0_gap got=%h exp=%h", obs0(), pk0(4'd3, 1'b0, 1'b1, 1'b0, 4'd0));
                else passed++;
            end
        end
        stop0();
        bus0.len = 4'd3; bus0.loop = 1'b0;
    endtask

    task automatic test_len_lowered();
        start0();
        repeat (26) tick();
        bus0.len = 4'd1;
        repeat (10) tick();
        total++;
        if (obs0() !== pk0(4'd7, 1'b0, 1'b1, 1'b0, 4'd2))
            $display("FAIL len_low_c36 got=%h exp=%h", obs0(), pk0(4'd7, 1'b0, 1'b1, 1'b0, 4'd2));
        else passed++;
        tick();
        total++;
        if (obs0() !== pk0(4'd0, 1'b0, 1'b0, 1'b1, 4'd2))
            $display("FAIL len_low_c37 got=%h exp=%h", obs0(), pk0(4'd0, 1'b0, 1'b0, 1'b1, 4'd2));
        else passed++;
        bus0.len = 4'd3;
        tick();
    endtask

    task automatic test_fast();
        logic [8:0] e, o;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            e = (c <= 4) ? {4'd0, 1'b0, 1'b1, 1'b0, 2'(c - 1)} : {4'd0, 1'b0, 1'b0, 1'b1, 2'd3};
            o = {bus1.note, bus1.gate, bus1.busy, bus1.done, bus1.step};
            total++;
            if (o !== e) $display("FAIL fast c=%0d got=%h exp=%h", c, o, e);
            else passed++;
        end
    endtask

    task automatic test_async_reset_ram();
        logic [10:0] e;
        start0();
        repeat (3) tick();
        total++;
        if ({bus0.note, bus0.gate} !== 5'b0011_1) $display("FAIL areset_pre got=%b exp=00111", {bus0.note, bus0.gate});
        else passed++;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (obs0() !== 11'd0) $display("FAIL areset_now got=%h exp=000", obs0());
        else passed++;
        #1;
        reset = 1'b0;
        tick();
        bus0.tempo = 24'd0; bus0.len = 4'd15; bus0.loop = 1'b0;
        start0();
        for (int c = 1; c <= 49; c++) begin
            tick();
            if (c <= 48) e = pk0(4'd0, 1'b0, 1'b1, 1'b0, 4'((c - 1) / 3));
            else e = pk0(4'd0, 1'b0, 1'b0, 1'b1, 4'd15);
            total++;
            if (obs0() !== e) $display("FAIL ram_rest c=%0d got=%h exp=%h", c, obs0(), e);
            else passed++;
        end
    endtask

    initial begin
        bus0.wr_en = 1'b0; bus0.wr_addr = '0; bus0.wr_data = '0; bus0.len = '0;
        bus0.tempo = '0; bus0.loop = 1'b0; bus0.start = 1'b0; bus0.stop = 1'b0;
        bus1.wr_en = 1'b0; bus1.wr_addr = '0; bus1.wr_data = '0; bus1.len = 2'd3;
        bus1.tempo = '0; bus1.loop = 1'b0; bus1.start = 1'b0; bus1.stop = 1'b0;
        test_reset();
        test_single_pass();
        test_loop_live_write();
        test_stop();
        test_start_stop_idle();
        test_start_while_busy();
        test_len_zero();
        test_len_lowered();
        test_fast();
        test_async_reset_ram();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Pattern sequencer for the triangle/PDM audio path. It steps through a small programmable pattern of notes at a programmable tempo. For each step it drives the triangle generator's 4-bit frequency select and a gate that the top level uses to mute the PCM/PDM output. Between notes it inserts a fixed articulation gap. It plays a pattern once or loops it, under start/stop control from the top-level inputs.

## Interface
- STEPS, 16, pattern depth; power of two, ≥2; AW = log2(STEPS)
- TEMPO_W, 24, width of tempo counter
- GAP_CYCLES, 1024, gate-low cycles after each note; 0 = no gap
- clk  in  1  clock; the only clock
- reset  in  1  asynchronous, active-high; top level derives it as !rst_n
- wr_en  in  1  write strobe for one pattern entry
- wr_addr  in  AW  entry index
- wr_data  in  5  {rest, note[3:0]}
- len  in  AW  index of last step (pattern length − 1)
- tempo  in  TEMPO_W  NOTE duration − 1, in cycles
- loop  in  1  1 = wrap to step 0 after last step
- start  in  1  one-cycle start request
- stop  in  1  one-cycle abort request
- note  out  4  frequency select to triangle generator
- gate  out  1  1 = note sounding
- step  out  AW  current step index
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse at natural end of a non-looping pattern

## Operation
- All outputs are registered. Reset values: note=0, gate=0, step=0, busy=0, done=0, state=IDLE. All pattern entries reset to rest=1, note=0.
- States: IDLE, NOTE, GAP.
- IDLE:
  - On start with stop low: load entry 0, set step=0, note=entry.note, gate=!entry.rest, busy=1.
  - Load tempo into the down-counter, then go to NOTE.
- NOTE lasts tempo+1 cycles. When the counter expires:
  - If GAP_CYCLES>0: go to GAP with gate=0 and note held.
  - If GAP_CYCLES=0: advance directly.
- GAP lasts GAP_CYCLES cycles, then advance.
- Advance:
  - If step ≥ len and loop=1: load step 0 and enter NOTE.
  - If step ≥ len and loop=0: go to IDLE with note=0, gate=0, busy=0, done=1 for one cycle. step keeps its last value.
  - Otherwise: step+1, load that entry, enter NOTE.
- len and loop are sampled live at each advance. tempo is sampled at each NOTE entry.
- stop in any state: IDLE on the next edge, gate=0, note=0, busy=0, no done.
- start+stop in the same cycle: stop wins.
- start while busy is ignored.
- Writes:
  - Accepted in every state.
  - A load in the same cycle as a write to the same address returns the old data (read-before-write).
  - Outputs for the step already playing never change mid-step.
- Rest entries: gate=0 for the entire step, note still driven from the entry.

## Timing
- start high at edge 0 → first note, gate, and busy visible after edge 1.
- Step period = tempo+1+GAP_CYCLES cycles.
- Step boundaries are gapless: the next entry's note/gate appears on the cycle after the last GAP (or NOTE) cycle.
- done is asserted exactly one cycle, coincident with busy falling.
- Asynchronous reset clears state, outputs, and RAM immediately, without waiting for a clock edge.

## Structure
- Package tone_seq_pkg holds:
  - state enum {IDLE, NOTE, GAP}
  - NOTE_W=4, ENTRY_W=5, REST_BIT=4
- Sub-module tone_seq_ram: STEPS×5 register array with:
  - async reset to rest
  - one write port
  - one registered read port with read-before-write behaviour
- Top-level instance feeds note into the triangle generator's frequency select, replacing ui_in[7:4].
- gate ANDs the PCM into the PDM modulator.

## Test plan
- Reset: assert reset mid-simulation without a clock edge → note=0, gate=0, busy=0 immediately. Reading every entry afterwards gives rest=1.
- Single pass, with GAP_CYCLES=2, tempo=9, len=3, loop=0, entries {3},{5},{rest},{9}, start at cycle 0:
  - note=3, gate=1 over cycles 1–10; gate=0 over 11–12.
  - note=5 over 13–22.
  - gate=0 throughout 25–36.
  - note=9 over 37–46.
  - done=1, busy=0 at cycle 49.
- Loop: same setup with loop=1 → at cycle 49 step=0, note=3, gate=1, busy=1, and done never asserts.
- Stop/start collisions:
  - stop during NOTE at cycle 5 → cycle 6 shows gate=0, busy=0, done=0.
  - start and stop together in IDLE → busy stays 0.
  - start during play → no effect.
- Live write: during step 1 NOTE, write entry 1=note 12 → note stays 5 until the step ends. On the next loop, step 1 plays note 12.
- Boundaries:
  - len=0 → a single step repeats when looping.
  - Lower len below the current step mid-play → the pattern ends at the next advance.
  - tempo=0, GAP_CYCLES=0 → step advances every cycle.
